// File: rtl/fetch_bpred_unit.sv
// ============================================================================
// Module      : fetch_bpred_unit
// Description : Instruction fetcher with a 2-bit saturating-counter BHT; checks
//               each conditional-branch prediction one cycle later and repairs
//               the PC on mispredict. Optional stats: FETCH_BPRED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_bpred_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] BHT_INIT    = 2'b10
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] init_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            prediction_is_invalid_o,
    input  logic            sig_decoder_is_branch_i,
    input  logic            sig_decoder_bcond_i,
    input  logic            sig_decoder_base_gpr_i,
    input  logic [XLEN-1:0] gpr_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            sig_executor_bcond_taken_i,
`ifdef FETCH_BPRED_STATS_EN
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispredicts_o,
`endif
    input  logic            sig_decoder_blocked_i
);

    localparam int c_IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic               pend_taken_q, pend_taken_d;
    logic [c_IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [XLEN-1:0]    pend_tgt_br_q, pend_tgt_br_d;
    logic [XLEN-1:0]    pend_tgt_def_q, pend_tgt_def_d;
    logic [1:0]         bht_q [BHT_ENTRIES];

    logic [XLEN-1:0]    w_pc_m4;
    logic [XLEN-1:0]    w_tgt_br;
    logic [XLEN-1:0]    w_tgt_def;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_pred_taken;
    logic               w_mispredict;
    logic               w_update;

    function automatic logic [1:0] f_sat(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!up && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

    // The decoder is one instruction behind fetch, so its branch lives at pc-4.
    assign w_pc_m4      = pc_q - XLEN'(4);
    assign w_tgt_br     = (sig_decoder_base_gpr_i ? gpr_i : w_pc_m4) + imm_i;
    assign w_tgt_def    = pc_q + XLEN'(4);
    assign w_idx        = w_pc_m4[c_IDX_W+1:2];
    assign w_pred_taken = bht_q[w_idx][1];
    assign w_mispredict = pend_valid_q && (pend_taken_q != sig_executor_bcond_taken_i);
    assign w_update     = !sig_decoder_blocked_i && pend_valid_q;

    assign pc_o                    = pc_q;
    assign imem_addr_o             = pc_q;
    assign prediction_is_invalid_o = w_mispredict;

    always_comb begin
        pc_d           = w_tgt_def;
        pend_valid_d   = sig_decoder_bcond_i && !w_mispredict;
        pend_taken_d   = w_pred_taken;
        pend_idx_d     = w_idx;
        pend_tgt_br_d  = w_tgt_br;
        pend_tgt_def_d = w_tgt_def;
        if (w_mispredict) begin
            // Wrong-path decode is squashed: only the repair target matters.
            pc_d = sig_executor_bcond_taken_i ? pend_tgt_br_q : pend_tgt_def_q;
        end else if (sig_decoder_is_branch_i && sig_decoder_bcond_i) begin
            pc_d = w_pred_taken ? w_tgt_br : w_tgt_def;
        end else if (sig_decoder_is_branch_i) begin
            pc_d = w_tgt_br;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pc_q           <= init_pc_i;
            pend_valid_q   <= 1'b0;
            pend_taken_q   <= 1'b0;
            pend_idx_q     <= '0;
            pend_tgt_br_q  <= '0;
            pend_tgt_def_q <= '0;
        end else if (!sig_decoder_blocked_i) begin
            pc_q           <= pc_d;
            pend_valid_q   <= pend_valid_d;
            pend_taken_q   <= pend_taken_d;
            pend_idx_q     <= pend_idx_d;
            pend_tgt_br_q  <= pend_tgt_br_d;
            pend_tgt_def_q <= pend_tgt_def_d;
        end
    end

    // Lookup reads the pre-update counter even when it aliases the update.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (w_update) begin
            bht_q[pend_idx_q] <= f_sat(bht_q[pend_idx_q], sig_executor_bcond_taken_i);
        end
    end

`ifdef FETCH_BPRED_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (w_update) begin
            if (stat_br_q != 32'hFFFF_FFFF) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (w_mispredict && stat_mis_q != 32'hFFFF_FFFF) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mis_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_i && w_update && w_mispredict) begin
            $display("fetch_bpred_unit: mispredict, branches=%0d mispredicts=%0d",
                     stat_br_q, stat_mis_q);
        end
    end
`endif
`endif

endmodule

`default_nettype wire
